// File: rtl/spi_shift_n.sv
// Full-duplex SPI shift engine: WIDTH-bit TX serialiser and RX deserialiser.
// The controller supplies separate sample and shift strobes, so either SPI clock phase can be used.
module spi_shift_n #(
    parameter int   WIDTH      = 8,
    parameter int   CNT_W      = 4,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             lsb_first,
    input  logic             sample_en,
    input  logic             shift_en,
    input  logic             s_in,
    output logic             s_out,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_cnt
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state;
    logic [WIDTH-1:0] tx_reg, rx_reg, tx_nxt, rx_nxt;
    logic             order;
    logic             last;

    always_comb begin
        tx_nxt = order ? {IDLE_LEVEL, tx_reg[WIDTH-1:1]} : {tx_reg[WIDTH-2:0], IDLE_LEVEL};
        rx_nxt = order ? {s_in, rx_reg[WIDTH-1:1]}       : {rx_reg[WIDTH-2:0], s_in};
        last   = sample_en && (bit_cnt == CNT_W'(WIDTH-1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            tx_reg   <= '0;
            rx_reg   <= '0;
            data_out <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            s_out    <= IDLE_LEVEL;
            order    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    s_out <= IDLE_LEVEL;
                    if (load) begin
                        tx_reg  <= data_in;
                        order   <= lsb_first;
                        rx_reg  <= '0;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= ACTIVE;
                        s_out   <= lsb_first ? data_in[0] : data_in[WIDTH-1];
                    end
                end
                ACTIVE: begin
                    if (sample_en) begin
                        rx_reg  <= rx_nxt;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                    // The completing sample wins over a coincident shift; the line returns to idle.
                    if (last) begin
                        data_out <= rx_nxt;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= IDLE;
                        s_out    <= IDLE_LEVEL;
                    end else if (shift_en) begin
                        tx_reg <= tx_nxt;
                        s_out  <= order ? tx_nxt[0] : tx_nxt[WIDTH-1];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/spi_shift_n.md
Name: spi_shift_n

Overview:
- Parametrised full-duplex SPI shift engine for the SPI LCD controller; successor to the fixed 8-bit load/shift register.
- Serialises a WIDTH-bit word on s_out and deserialises s_in into a parallel word.
- Has independent sample/shift strobes (supports either clock phase), runtime MSB/LSB order, a bit counter, and busy/done status. The controller FSM supplies strobes derived from its SCK generator.

Parameters:
- WIDTH, 8, transfer word width in bits (2..32).
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > WIDTH.
- IDLE_LEVEL, 0, s_out level when idle; also the fill bit shifted into the TX register.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low (rst=0 resets on next rising clk).
- load  in  1  start request; accepted only when busy=0.
- data_in  in  WIDTH  TX word, captured on accepted load.
- lsb_first  in  1  bit order, latched on accepted load (0=MSB first, 1=LSB first).
- sample_en  in  1  one-cycle strobe: capture s_in into RX register.
- shift_en  in  1  one-cycle strobe: advance TX register to next bit.
- s_in  in  1  serial input (MISO).
- s_out  out  1  serial output (MOSI), registered.
- data_out  out  WIDTH  last completed RX word; held until next completion.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse on transfer completion.
- bit_cnt  out  CNT_W  number of samples taken in current transfer.

Behaviour:
- Reset (rst=0): tx_reg=0, rx_reg=0, data_out=0, bit_cnt=0, busy=0, done=0, s_out=IDLE_LEVEL, state IDLE, latched order=MSB.
- States:
  - IDLE: busy=0.
  - ACTIVE: busy=1.
  - done is a registered pulse asserted in the first IDLE cycle after completion.
- IDLE, load=1:
  - tx_reg<=data_in, order latched, rx_reg<=0, bit_cnt<=0, busy<=1, state->ACTIVE.
  - s_out presents the first bit the next cycle: data_in[WIDTH-1] (MSB) or data_in[0] (LSB).
- IDLE: sample_en and shift_en are ignored; s_out=IDLE_LEVEL.
- ACTIVE, sample_en=1:
  - MSB order: rx_reg<={rx_reg[WIDTH-2:0],s_in}.
  - LSB order: rx_reg<={s_in,rx_reg[WIDTH-1:1]}.
  - bit_cnt<=bit_cnt+1.
- ACTIVE, shift_en=1:
  - MSB order: tx_reg<={tx_reg[WIDTH-2:0],IDLE_LEVEL}.
  - LSB order: tx_reg<={IDLE_LEVEL,tx_reg[WIDTH-1:1]}.
  - s_out follows the new current bit one cycle later (registered).
- sample_en and shift_en in the same cycle: both actions take effect.
- Completion: the sample_en that makes bit_cnt reach WIDTH causes:
  - data_out<=the fully assembled word, including that final s_in bit.
  - busy<=0, state->IDLE, done=1 for exactly the next cycle.
  - bit_cnt holds WIDTH until the next accepted load.
  - A shift_en in the completing cycle is ignored.
- load while busy=1: ignored; no effect on any register.
- load during the done cycle: accepted (busy=0); done still pulses for one cycle only.
- Extra shift_en beyond WIDTH-1 within a transfer: TX fills with IDLE_LEVEL; no error.
- lsb_first changes mid-transfer: no effect until the next accepted load.
- rst=0 mid-transfer: immediate return to reset values on that edge; no done pulse; data_out cleared.
- Latency: load->busy=1 is 1 cycle. Final sample_en->data_out valid and done=1 is 1 cycle.

Test Plan:
- WIDTH=8, MSB first, load 0xA5, s_out looped to s_in, alternating shift_en/sample_en:
  - s_out sequence must be 1,0,1,0,0,1,0,1.
  - After the 8th sample: data_out=0xA5, done high exactly 1 cycle, busy=0, bit_cnt=8.
- LSB first, load 0x01, s_in driven 1,1,0,0,0,0,0,0 over 8 samples:
  - s_out first bit=1, then 0s.
  - data_out=0x03.
- Busy guard: load 0x3C, then assert load with data_in=0xFF after 3 samples:
  - Transfer continues unchanged; looped-back data_out=0x3C.
  - No second done pulse.
- Reset mid-transfer: load 0x96, take 4 samples, pull rst=0 one cycle:
  - All outputs at reset values, no done pulse.
  - A following load of 0x5A completes with data_out=0x5A.
- Simultaneous strobes: sample_en and shift_en asserted together on every strobe, s_in tied 1, load 0x00:
  - data_out=0xFF after 8 strobes, s_out=0 throughout.
- WIDTH=16, CNT_W=5 instance, load 0xBEEF with loopback, MSB first:
  - data_out=0xBEEF, bit_cnt=16, done pulse once.
  - Back-to-back load 0x1234 in the done cycle is accepted and yields 0x1234.
